traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Receive-side checker for the 8-bit light bus {north,east,south,west} driven by the traffic FSM.
//  Decodes the lights back to a phase code, measures dwell time per phase, and flags:
//  conflicting greens, illegal codes, out-of-order phases and wrong dwell times.
//  Sits beside the controller (same clk domain), outputs go to status pins / bench scoreboard.
// PARAMETERS
//  CLKS_PER_SEC  50_000_000  clk cycles per second of light timing
//  GREEN_SEC     5           required green-phase dwell, seconds
//  YELLOW_SEC    1           required yellow-phase dwell, seconds
//  RST_MAX_SEC   25          max dwell in all-yellow RST phase before timeout
//  TOL_CLKS      1           allowed |dwell - expected| in clk cycles
//  CNT_W         32          dwell counter width (saturating)
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-low reset
//  lights       in   8      {N,E,S,W}, 2b each: 00 red, 01 yellow, 10 green, 11 illegal
//  err_clr      in   1      clears err_sticky (sync, 1-cycle pulse)
//  phase        out  4      decoded phase: 0 RST,1..8 S0..S7, 9 ALLRED, F UNKNOWN
//  phase_change out  1      1-cycle pulse when phase register changes
//  dwell_sec    out  5      whole seconds in current phase, saturates at 31
//  err_conflict out  1      pulse: >1 green, or green with any yellow
//  err_illegal  out  1      pulse: any field == 2'b11
//  err_sequence out  1      pulse: illegal phase transition
//  err_timing   out  1      pulse: dwell out of tolerance (early exit or timeout)
//  err_sticky   out  4      {timing,sequence,illegal,conflict} sticky flags
//  cycle_done   out  1      pulse on S7->S0 with no error since previous S0
//  cycle_cnt    out  8      completed S7->S0 cycles, wraps 255->0
// BEHAVIOUR
//  - Reset: phase=F, dwell=0, dwell_sec=0, all pulses 0, err_sticky=0, cycle_cnt=0, first=1.
//  - Latency 1: every clk edge phase<=decode(lights); pulses registered on the same edge.
//  - Decode: YYYY->0; GRRR->1; YYRR->2; RGRR->3; RYYR->4; RRGR->5; RRYY->6; RRRG->7;
//    YRRY->8; RRRR->9; anything else->F.
//  - err_conflict/err_illegal: asserted every cycle the condition holds on lights.
//  - Legal transitions: hold; Sk->Sk+1 (k=0..6); S7->S0; RST->S0; any->RST; any->ALLRED;
//    ALLRED->RST. Any other change, incl. into/out of F, -> err_sequence on change edge.
//  - Dwell: on entry dwell=1, +1 per held cycle, saturates at 2^CNT_W-1; sec prescaler
//    restarts on entry, dwell_sec increments every CLKS_PER_SEC cycles.
//  - Expected: S0,S2,S4,S6 = GREEN_SEC*CLKS_PER_SEC; S1,S3,S5,S7 = YELLOW_SEC*CLKS_PER_SEC.
//  - Early exit: on legal change out of a timed phase with dwell < exp-TOL_CLKS -> err_timing.
//  - Timeout: dwell reaching exp+TOL_CLKS+1 (RST: RST_MAX_SEC*CLKS_PER_SEC+1) -> one
//    err_timing pulse per phase visit; no further timing check on that exit.
//  - first=1 suppresses timing check for the first phase seen after reset; cleared on 1st change.
//  - err_sticky bits set by pulses; err_clr clears; set wins if same cycle.
//  - cycle_done/cycle_cnt++ on S7->S0 only if no error pulse since last S0 entry.
//  - Reset mid-operation: immediate async return to reset values; in-progress visit discarded.
// STRUCTURE
//  - traffic_pkg: light codes (RED/YELLOW/GREEN/ILLEGAL), phase codes, decode function,
//    legal-successor function.
//  - Sub-module traffic_dwell_timer: dwell counter + second prescaler, restart on phase_change,
//    timeout compare output.
//  - Top: phase register, transition/sequence check, error pulses/sticky, cycle counter.
// TESTING (CLKS_PER_SEC=4, GREEN_SEC=5, YELLOW_SEC=1, TOL_CLKS=1)
//  1 nominal: RST 1clk, S0 20, S1 4, S2 20 ... S7 4, S0 -> phases 0,1..8,1; no errors; cycle_cnt=1.
//  2 tolerance: S0 held 19 then S1 -> no error; S0 held 17 then S1 -> err_timing on S1 entry.
//  3 stuck: S0 held 30 clks -> single err_timing when dwell=22, none on exit; err_sticky[3]=1.
//  4 conflict: lights=8'b10_10_00_00 -> err_conflict each cycle, phase=F; err_clr -> sticky 0.
//  5 order/illegal: S0 -> S2 -> err_sequence; lights=8'b11_00_00_00 -> err_illegal, phase=F.
//  6 reset mid-S3 (dwell 2) -> all outputs reset values; next phase timing check suppressed.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  traffic_pkg
//  Light and phase encodings plus decode / legal-successor helpers for the
//  traffic light monitor.
//  Revision: 1.0
// ============================================================================
package traffic_pkg;

    localparam logic [1:0] c_LIGHT_RED     = 2'b00;
    localparam logic [1:0] c_LIGHT_YELLOW  = 2'b01;
    localparam logic [1:0] c_LIGHT_GREEN   = 2'b10;
    localparam logic [1:0] c_LIGHT_ILLEGAL = 2'b11;

    localparam logic [3:0] c_PH_RST     = 4'h0;
    localparam logic [3:0] c_PH_S0      = 4'h1;
    localparam logic [3:0] c_PH_S1      = 4'h2;
    localparam logic [3:0] c_PH_S2      = 4'h3;
    localparam logic [3:0] c_PH_S3      = 4'h4;
    localparam logic [3:0] c_PH_S4      = 4'h5;
    localparam logic [3:0] c_PH_S5      = 4'h6;
    localparam logic [3:0] c_PH_S6      = 4'h7;
    localparam logic [3:0] c_PH_S7      = 4'h8;
    localparam logic [3:0] c_PH_ALLRED  = 4'h9;
    localparam logic [3:0] c_PH_UNKNOWN = 4'hF;

    // Bus layout is {N,E,S,W}, two bits per direction.
    function automatic logic [3:0] decode_lights(input logic [7:0] lights);
        case (lights)
            8'h55:   return c_PH_RST;
            8'h80:   return c_PH_S0;
            8'h50:   return c_PH_S1;
            8'h20:   return c_PH_S2;
            8'h14:   return c_PH_S3;
            8'h08:   return c_PH_S4;
            8'h05:   return c_PH_S5;
            8'h02:   return c_PH_S6;
            8'h41:   return c_PH_S7;
            8'h00:   return c_PH_ALLRED;
            default: return c_PH_UNKNOWN;
        endcase
    endfunction

    function automatic logic is_timed(input logic [3:0] ph);
        return (ph >= c_PH_S0) && (ph <= c_PH_S7);
    endfunction

    function automatic logic is_legal_step(input logic [3:0] from_ph, input logic [3:0] to_ph);
        if (to_ph == from_ph)                             return 1'b1;
        if (to_ph == c_PH_RST || to_ph == c_PH_ALLRED)    return 1'b1;
        if (from_ph == c_PH_RST && to_ph == c_PH_S0)      return 1'b1;
        if (from_ph == c_PH_S7 && to_ph == c_PH_S0)       return 1'b1;
        if (from_ph >= c_PH_S0 && from_ph < c_PH_S7 && to_ph == from_ph + 4'd1)
            return 1'b1;
        return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_monitor_dwell_timer.sv
`default_nettype none
// ============================================================================
//  traffic_dwell_timer
//  Saturating dwell counter and per-second prescaler, restarted on phase entry.
//  Revision: 1.0
// ============================================================================
module traffic_dwell_timer #(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_restart,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_dwell,
    output logic [4:0]       o_dwell_sec,
    output logic             o_timeout_hit
);

    localparam int               c_PRESC_W    = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(CLKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] c_DWELL_MAX  = '1;

    logic [CNT_W-1:0]     r_dwell;
    logic [c_PRESC_W-1:0] r_presc;
    logic [4:0]           r_sec;

    logic [CNT_W-1:0]     w_dwell_base;
    logic [CNT_W-1:0]     w_dwell_inc;
    logic [c_PRESC_W-1:0] w_presc_base;
    logic [4:0]           w_sec_base;

    // A restart behaves as "clear, then count this cycle", so entry gives dwell=1.
    always_comb begin
        w_dwell_base  = i_restart ? '0 : r_dwell;
        w_presc_base  = i_restart ? '0 : r_presc;
        w_sec_base    = i_restart ? '0 : r_sec;
        w_dwell_inc   = w_dwell_base + CNT_W'(1);
        o_timeout_hit = !i_restart && (w_dwell_base != c_DWELL_MAX) && (w_dwell_inc == i_limit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dwell <= '0;
            r_presc <= '0;
            r_sec   <= '0;
        end else begin
            r_dwell <= (w_dwell_base != c_DWELL_MAX) ? w_dwell_inc : w_dwell_base;
            if (w_presc_base == c_PRESC_LAST) begin
                r_presc <= '0;
                r_sec   <= (w_sec_base != 5'd31) ? w_sec_base + 5'd1 : w_sec_base;
            end else begin
                r_presc <= w_presc_base + c_PRESC_W'(1);
                r_sec   <= w_sec_base;
            end
        end
    end

    assign o_dwell     = r_dwell;
    assign o_dwell_sec = r_sec;

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  traffic_light_monitor
//  Decodes the light bus to a phase and flags conflicts, illegal codes,
//  sequence violations and dwell-time errors; counts clean full cycles.
//  Revision: 1.0
// ============================================================================
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int GREEN_SEC    = 5,
    parameter int YELLOW_SEC   = 1,
    parameter int RST_MAX_SEC  = 25,
    parameter int TOL_CLKS     = 1,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] lights,
    input  logic       err_clr,
    output logic [3:0] phase,
    output logic       phase_change,
    output logic [4:0] dwell_sec,
    output logic       err_conflict,
    output logic       err_illegal,
    output logic       err_sequence,
    output logic       err_timing,
    output logic [3:0] err_sticky,
    output logic       cycle_done,
    output logic [7:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] c_GREEN_CLKS   = CNT_W'(longint'(GREEN_SEC) * longint'(CLKS_PER_SEC));
    localparam logic [CNT_W-1:0] c_YELLOW_CLKS  = CNT_W'(longint'(YELLOW_SEC) * longint'(CLKS_PER_SEC));
    localparam logic [CNT_W-1:0] c_GREEN_MIN    = c_GREEN_CLKS - CNT_W'(TOL_CLKS);
    localparam logic [CNT_W-1:0] c_YELLOW_MIN   = c_YELLOW_CLKS - CNT_W'(TOL_CLKS);
    localparam logic [CNT_W-1:0] c_GREEN_LIMIT  = c_GREEN_CLKS + CNT_W'(TOL_CLKS) + CNT_W'(1);
    localparam logic [CNT_W-1:0] c_YELLOW_LIMIT = c_YELLOW_CLKS + CNT_W'(TOL_CLKS) + CNT_W'(1);
    localparam logic [CNT_W-1:0] c_RST_LIMIT    = CNT_W'(longint'(RST_MAX_SEC) * longint'(CLKS_PER_SEC) + 1);

    logic [3:0] r_phase;
    logic       r_phase_change;
    logic       r_err_conflict, r_err_illegal, r_err_sequence, r_err_timing;
    logic [3:0] r_sticky;
    logic       r_first;
    logic       r_timed_out;
    logic       r_clean;
    logic       r_cycle_done;
    logic [7:0] r_cycle_cnt;

    logic [3:0]       w_next;
    logic             w_change, w_legal;
    logic [2:0]       w_n_green;
    logic             w_any_yellow, w_any_illegal;
    logic             w_conflict, w_seq_err, w_early, w_timeout, w_timing, w_any_err;
    logic [CNT_W-1:0] w_min_dwell, w_limit, w_dwell;
    logic             w_timeout_hit;
    logic [3:0]       w_err_vec;

    // Odd phase codes (S0,S2,S4,S6) are the green phases.
    always_comb begin
        w_next        = decode_lights(lights);
        w_change      = (w_next != r_phase);
        w_legal       = is_legal_step(r_phase, w_next);
        w_n_green     = '0;
        w_any_yellow  = 1'b0;
        w_any_illegal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lights[2*i +: 2] == c_LIGHT_GREEN)   w_n_green = w_n_green + 3'd1;
            if (lights[2*i +: 2] == c_LIGHT_YELLOW)  w_any_yellow = 1'b1;
            if (lights[2*i +: 2] == c_LIGHT_ILLEGAL) w_any_illegal = 1'b1;
        end
        w_conflict  = (w_n_green > 3'd1) || ((w_n_green != 3'd0) && w_any_yellow);
        w_seq_err   = w_change && !w_legal;
        w_min_dwell = r_phase[0] ? c_GREEN_MIN : c_YELLOW_MIN;
        w_early     = w_change && w_legal && is_timed(r_phase) && !r_first
                      && !r_timed_out && (w_dwell < w_min_dwell);
        if (is_timed(w_next)) w_limit = w_next[0] ? c_GREEN_LIMIT : c_YELLOW_LIMIT;
        else                  w_limit = c_RST_LIMIT;
        w_timeout   = w_timeout_hit && !r_first && (is_timed(w_next) || w_next == c_PH_RST);
        w_timing    = w_early || w_timeout;
        w_err_vec   = {w_timing, w_seq_err, w_any_illegal, w_conflict};
        w_any_err   = |w_err_vec;
    end

    traffic_dwell_timer #(
        .CLKS_PER_SEC (CLKS_PER_SEC),
        .CNT_W        (CNT_W)
    ) u_dwell_timer (
        .clk           (clk),
        .reset         (reset),
        .i_restart     (w_change),
        .i_limit       (w_limit),
        .o_dwell       (w_dwell),
        .o_dwell_sec   (dwell_sec),
        .o_timeout_hit (w_timeout_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase        <= c_PH_UNKNOWN;
            r_phase_change <= 1'b0;
            r_err_conflict <= 1'b0;
            r_err_illegal  <= 1'b0;
            r_err_sequence <= 1'b0;
            r_err_timing   <= 1'b0;
            r_sticky       <= '0;
            r_first        <= 1'b1;
            r_timed_out    <= 1'b0;
            r_clean        <= 1'b0;
            r_cycle_done   <= 1'b0;
            r_cycle_cnt    <= '0;
        end else begin
            r_phase        <= w_next;
            r_phase_change <= w_change;
            r_err_conflict <= w_conflict;
            r_err_illegal  <= w_any_illegal;
            r_err_sequence <= w_seq_err;
            r_err_timing   <= w_timing;
            r_sticky       <= (err_clr ? 4'b0000 : r_sticky) | w_err_vec;
            // The visit entered straight out of reset is partial, so its exit stays unchecked.
            if (w_change && r_phase != c_PH_UNKNOWN) r_first <= 1'b0;
            if (w_change)       r_timed_out <= 1'b0;
            else if (w_timeout) r_timed_out <= 1'b1;
            r_cycle_done <= 1'b0;
            if (w_change && w_next == c_PH_S0) begin
                if (r_phase == c_PH_S7 && r_clean && !w_any_err) begin
                    r_cycle_done <= 1'b1;
                    r_cycle_cnt  <= r_cycle_cnt + 8'd1;
                end
                r_clean <= !w_any_err;
            end else if (w_any_err) begin
                r_clean <= 1'b0;
            end
        end
    end

    assign phase        = r_phase;
    assign phase_change = r_phase_change;
    assign err_conflict = r_err_conflict;
    assign err_illegal  = r_err_illegal;
    assign err_sequence = r_err_sequence;
    assign err_timing   = r_err_timing;
    assign err_sticky   = r_sticky;
    assign cycle_done   = r_cycle_done;
    assign cycle_cnt    = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  tb_traffic_light_monitor
//  Directed self-checking bench with a 4-clock "second" for short dwell times.
//  Revision: 1.0
// ============================================================================
module tb_traffic_light_monitor;

    localparam logic [7:0] L_RST = 8'h55, L_S0 = 8'h80, L_S1 = 8'h50, L_S2 = 8'h20;
    localparam logic [7:0] L_S3  = 8'h14, L_S4 = 8'h08, L_S5 = 8'h05, L_S6 = 8'h02;
    localparam logic [7:0] L_S7  = 8'h41, L_ALLRED = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] lights = 8'h55;
    logic       err_clr = 1'b0;
    logic [3:0] phase;
    logic       phase_change;
    logic [4:0] dwell_sec;
    logic       err_conflict, err_illegal, err_sequence, err_timing;
    logic [3:0] err_sticky;
    logic       cycle_done;
    logic [7:0] cycle_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] seq_l [8];
    int         seq_n [8];

    traffic_light_monitor #(
        .CLKS_PER_SEC (4),
        .GREEN_SEC    (5),
        .YELLOW_SEC   (1),
        .RST_MAX_SEC  (25),
        .TOL_CLKS     (1),
        .CNT_W        (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lights       (lights),
        .err_clr      (err_clr),
        .phase        (phase),
        .phase_change (phase_change),
        .dwell_sec    (dwell_sec),
        .err_conflict (err_conflict),
        .err_illegal  (err_illegal),
        .err_sequence (err_sequence),
        .err_timing   (err_timing),
        .err_sticky   (err_sticky),
        .cycle_done   (cycle_done),
        .cycle_cnt    (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [7:0] v);
        lights = v;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        repeat (n) step(v);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        err_clr = 1'b0;
        lights  = L_RST;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (phase !== 4'hF) begin n_bad++; $display("FAIL reset_phase got=%h exp=F", phase); end
        n_cmp++; if ({phase_change, err_conflict, err_illegal, err_sequence, err_timing, cycle_done} !== 6'b0) begin
            n_bad++; $display("FAIL reset_pulses got=%b exp=000000",
                {phase_change, err_conflict, err_illegal, err_sequence, err_timing, cycle_done});
        end
        n_cmp++; if ({err_sticky, cycle_cnt, dwell_sec} !== 17'd0) begin
            n_bad++; $display("FAIL reset_counters sticky=%h cnt=%0d sec=%0d exp=0", err_sticky, cycle_cnt, dwell_sec);
        end
        reset = 1'b1;
    endtask

    task automatic test_nominal();
        logic [3:0] seen;
        seen = 4'b0;
        do_reset();
        step(L_RST);
        n_cmp++; if (phase !== 4'h0 || phase_change !== 1'b1) begin
            n_bad++; $display("FAIL nominal_rst got phase=%h chg=%b exp=0/1", phase, phase_change);
        end
        for (int k = 0; k < 8; k++) begin
            step(seq_l[k]);
            seen |= {err_timing, err_sequence, err_illegal, err_conflict};
            n_cmp++; if (phase !== 4'(k + 1)) begin
                n_bad++; $display("FAIL nominal_phase got=%h exp=%h", phase, 4'(k + 1));
            end
            for (int j = 1; j < seq_n[k]; j++) begin
                step(seq_l[k]);
                seen |= {err_timing, err_sequence, err_illegal, err_conflict};
            end
            if (k == 0) begin
                n_cmp++; if (dwell_sec !== 5'd5) begin n_bad++; $display("FAIL nominal_dwell_sec got=%0d exp=5", dwell_sec); end
            end
        end
        step(L_S0);
        seen |= {err_timing, err_sequence, err_illegal, err_conflict};
        n_cmp++; if (seen !== 4'b0) begin n_bad++; $display("FAIL nominal_errors got=%b exp=0000", seen); end
        n_cmp++; if (phase !== 4'h1 || cycle_done !== 1'b1 || cycle_cnt !== 8'd1) begin
            n_bad++; $display("FAIL nominal_cycle got phase=%h done=%b cnt=%0d exp=1/1/1", phase, cycle_done, cycle_cnt);
        end
        step(L_S0);
        n_cmp++; if (cycle_done !== 1'b0) begin n_bad++; $display("FAIL nominal_done_pulse got=%b exp=0", cycle_done); end
    endtask

    task automatic test_tolerance();
        do_reset();
        step(L_RST);
        hold(L_S0, 19);
        step(L_S1);
        n_cmp++; if (err_timing !== 1'b0 || phase !== 4'h2) begin
            n_bad++; $display("FAIL tol_19 got timing=%b phase=%h exp=0/2", err_timing, phase);
        end
        do_reset();
        step(L_RST);
        hold(L_S0, 17);
        step(L_S1);
        n_cmp++; if (err_timing !== 1'b1) begin n_bad++; $display("FAIL tol_17 got timing=%b exp=1", err_timing); end
        n_cmp++; if (err_sticky !== 4'b1000) begin n_bad++; $display("FAIL tol_sticky got=%b exp=1000", err_sticky); end
    endtask

    task automatic test_stuck();
        int hits;
        int at;
        hits = 0;
        at   = 0;
        do_reset();
        step(L_RST);
        for (int i = 1; i <= 30; i++) begin
            step(L_S0);
            if (err_timing === 1'b1) begin hits++; at = i; end
        end
        n_cmp++; if (hits != 1 || at != 22) begin
            n_bad++; $display("FAIL stuck_timeout got hits=%0d at=%0d exp=1/22", hits, at);
        end
        step(L_S1);
        n_cmp++; if (err_timing !== 1'b0 || err_sequence !== 1'b0) begin
            n_bad++; $display("FAIL stuck_exit got timing=%b seq=%b exp=0/0", err_timing, err_sequence);
        end
        n_cmp++; if (err_sticky[3] !== 1'b1) begin n_bad++; $display("FAIL stuck_sticky got=%b exp=1", err_sticky[3]); end
    endtask

    task automatic test_conflict();
        do_reset();
        step(L_RST);
        for (int i = 0; i < 3; i++) begin
            step(8'hA0);
            n_cmp++; if (err_conflict !== 1'b1 || phase !== 4'hF) begin
                n_bad++; $display("FAIL conflict_cycle got conf=%b phase=%h exp=1/F", err_conflict, phase);
            end
        end
        step(L_ALLRED);
        n_cmp++; if (err_conflict !== 1'b0 || phase !== 4'h9 || err_sticky[0] !== 1'b1) begin
            n_bad++; $display("FAIL conflict_allred got conf=%b phase=%h sticky0=%b exp=0/9/1",
                err_conflict, phase, err_sticky[0]);
        end
        err_clr = 1'b1;
        step(L_ALLRED);
        err_clr = 1'b0;
        n_cmp++; if (err_sticky !== 4'b0) begin n_bad++; $display("FAIL conflict_clr got=%b exp=0000", err_sticky); end
    endtask

    task automatic test_order();
        do_reset();
        step(L_RST);
        hold(L_S0, 3);
        step(L_S2);
        n_cmp++; if (err_sequence !== 1'b1 || phase !== 4'h3 || err_timing !== 1'b0) begin
            n_bad++; $display("FAIL order_skip got seq=%b phase=%h timing=%b exp=1/3/0", err_sequence, phase, err_timing);
        end
        step(8'hC0);
        n_cmp++; if (err_illegal !== 1'b1 || phase !== 4'hF || err_conflict !== 1'b0) begin
            n_bad++; $display("FAIL order_illegal got ill=%b phase=%h conf=%b exp=1/F/0", err_illegal, phase, err_conflict);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(L_RST);
        for (int k = 0; k < 8; k++) hold(seq_l[k], seq_n[k]);
        hold(L_S0, 20);
        hold(L_S1, 4);
        hold(L_S2, 20);
        hold(L_S3, 2);
        n_cmp++; if (phase !== 4'h4 || cycle_cnt !== 8'd1) begin
            n_bad++; $display("FAIL mid_before got phase=%h cnt=%0d exp=4/1", phase, cycle_cnt);
        end
        reset = 1'b0;
        #2;
        n_cmp++; if (phase !== 4'hF || cycle_cnt !== 8'd0 || dwell_sec !== 5'd0 || err_sticky !== 4'b0) begin
            n_bad++; $display("FAIL mid_async got phase=%h cnt=%0d sec=%0d sticky=%b exp=F/0/0/0",
                phase, cycle_cnt, dwell_sec, err_sticky);
        end
        #2;
        reset = 1'b1;
        step(L_S3);
        n_cmp++; if (phase !== 4'h4) begin n_bad++; $display("FAIL mid_resume got=%h exp=4", phase); end
        step(L_S3);
        step(L_S4);
        n_cmp++; if (err_timing !== 1'b0 || phase !== 4'h5) begin
            n_bad++; $display("FAIL mid_first_suppressed got timing=%b phase=%h exp=0/5", err_timing, phase);
        end
        hold(L_S4, 2);
        step(L_S5);
        n_cmp++; if (err_timing !== 1'b1) begin n_bad++; $display("FAIL mid_second_checked got=%b exp=1", err_timing); end
    endtask

    initial begin
        seq_l = '{L_S0, L_S1, L_S2, L_S3, L_S4, L_S5, L_S6, L_S7};
        seq_n = '{20, 4, 20, 4, 20, 4, 20, 4};
        #3;
        test_reset();
        test_nominal();
        test_tolerance();
        test_stuck();
        test_conflict();
        test_order();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
